// File: rtl/vram_arbiter.sv
// Fixed-priority arbiter for the single-port text RAM: video read > clear sweep > terminal.
// Owns the screen-clear FSM and routes the 1-cycle-latency read data back to its requester.
module vram_arbiter #(
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 16,
  parameter int                DEPTH  = 2400,
  parameter logic [DATA_W-1:0] BLANK  = 16'h0720
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  input  logic              term_req,
  input  logic              term_we,
  input  logic [ADDR_W-1:0] term_addr,
  input  logic [DATA_W-1:0] term_wdata,
  output logic              term_ack,
  output logic [DATA_W-1:0] term_rdata,
  output logic              term_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clr_done_q, clr_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_tag_q, rd_tag_d;   // 0 = video, 1 = terminal
  logic              rd_oor_q, rd_oor_d;

  logic gnt_vid, gnt_clr, gnt_term, term_oor;

  assign clr_busy = (state_q == S_CLEAR);
  assign term_oor = (term_addr > LAST);

  // Grants are suppressed while rst is high so nothing touches the RAM during reset.
  assign gnt_vid  = !rst && vid_req;
  assign gnt_clr  = !rst && !vid_req && clr_busy;
  assign gnt_term = !rst && !vid_req && !clr_busy && term_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
      rd_pend_q  <= rd_pend_d;
      rd_tag_q   <= rd_tag_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  // A restart wins over completion, so an aborted pass never pulses clr_done.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_start) begin
          clr_ptr_d = '0;
        end else if (gnt_clr) begin
          if (clr_ptr_q == LAST) begin
            state_d    = S_IDLE;
            clr_ptr_d  = '0;
            clr_done_d = 1'b1;
          end else begin
            clr_ptr_d = clr_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    term_ack  = 1'b0;
    rd_pend_d = 1'b0;
    rd_tag_d  = 1'b0;
    rd_oor_d  = 1'b0;
    if (gnt_vid) begin
      mem_addr  = vid_addr;
      rd_pend_d = 1'b1;
    end else if (gnt_clr) begin
      mem_addr  = clr_ptr_q;
      mem_wdata = BLANK;
      mem_we    = 1'b1;
    end else if (gnt_term) begin
      term_ack  = 1'b1;
      mem_addr  = term_addr;
      mem_wdata = term_we ? term_wdata : '0;
      mem_we    = term_we && !term_oor;
      rd_pend_d = !term_we;
      rd_tag_d  = 1'b1;
      rd_oor_d  = term_oor;
    end
  end

  assign clr_done    = clr_done_q;
  assign vid_valid   = rd_pend_q && !rd_tag_q;
  assign term_rvalid = rd_pend_q && rd_tag_q;
  assign vid_rdata   = vid_valid ? mem_rdata : '0;
  assign term_rdata  = (term_rvalid && !rd_oor_q) ? mem_rdata : '0;

endmodule
